// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// slave = the LSU itself, master = the core plus memory environment driving it.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [2:0]        lsu_funct3_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [31:0]       lsu_wdata_i;
  logic              lsu_busy_o;
  logic              lsu_done_o;
  logic              lsu_err_o;
  logic [31:0]       lsu_rdata_o;
  logic              ctrl_mem_ren_o;
  logic              ctrl_mem_wren_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i,
    output lsu_busy_o, lsu_done_o, lsu_err_o, lsu_rdata_o,
    output ctrl_mem_ren_o, ctrl_mem_wren_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output lsu_req_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i,
    input  lsu_busy_o, lsu_done_o, lsu_err_o, lsu_rdata_o,
    input  ctrl_mem_ren_o, ctrl_mem_wren_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_mem_port.sv
// LSU to a 1-cycle registered-read, 4-byte-write memory; optional misalignment trap via LSU_MISALIGN_TRAP_EN.
// Latency from accept: load 2, SW 1, SB/SH 2 (read-modify-write); requests are ignored while lsu_busy_o=1.
module lsu_mem_port #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW       = 2'd2
  } state_t;

  state_t            state;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-3:0] waddr_q;

  logic        req_word;
  logic        req_half;
  logic        accept;
  logic        trap;
  logic [1:0]  req_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        ren_c;
  logic        wren_c;
  logic [ADDR_W-1:0] addr_c;
  logic [31:0] wdat_c;

  // funct3[1] set covers LW and the reserved encodings 011/110/111.
  assign req_word = bus.lsu_funct3_i[1];
  assign req_half = !bus.lsu_funct3_i[1] && bus.lsu_funct3_i[0];
  assign accept   = (state == IDLE) && bus.lsu_req_i;

  // Natural alignment truncation; a trap fires exactly when truncation would change the offset.
  always_comb begin
    if (req_word) begin
      req_off = 2'b00;
    end else if (req_half) begin
      req_off = {bus.lsu_addr_i[1], 1'b0};
    end else begin
      req_off = bus.lsu_addr_i[1:0];
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = accept && (req_off != bus.lsu_addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.mem_rdata_i[7:0];
      2'd1:    ld_byte = bus.mem_rdata_i[15:8];
      2'd2:    ld_byte = bus.mem_rdata_i[23:16];
      default: ld_byte = bus.mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    if (funct3_q[1]) begin
      ld_ext = bus.mem_rdata_i;
    end else if (funct3_q[0]) begin
      ld_ext = {{16{ld_half[15] & !funct3_q[2]}}, ld_half};
    end else begin
      ld_ext = {{24{ld_byte[7] & !funct3_q[2]}}, ld_byte};
    end
  end

  always_comb begin
    merged = bus.mem_rdata_i;
    if (funct3_q[0]) begin
      if (off_q[1]) begin
        merged[31:16] = wdata_q;
      end else begin
        merged[15:0] = wdata_q;
      end
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Memory side is combinational so reads and word writes go out in the accept cycle.
  always_comb begin
    ren_c  = 1'b0;
    wren_c = 1'b0;
    addr_c = '0;
    wdat_c = '0;
    if (state == RMW) begin
      wren_c = 1'b1;
      addr_c = {waddr_q, 2'b00};
      wdat_c = merged;
    end else if (accept && !trap) begin
      addr_c = {bus.lsu_addr_i[ADDR_W-1:2], 2'b00};
      if (bus.lsu_we_i && req_word) begin
        wren_c = 1'b1;
        wdat_c = bus.lsu_wdata_i;
      end else begin
        ren_c = 1'b1;
      end
    end
  end

  assign bus.ctrl_mem_ren_o  = ren_c;
  assign bus.ctrl_mem_wren_o = wren_c;
  assign bus.mem_addr_o      = addr_c;
  assign bus.mem_wdata_o     = wdat_c;
  assign bus.lsu_busy_o      = busy_q;
  assign bus.lsu_done_o      = done_q;
  assign bus.lsu_err_o       = err_q;
  assign bus.lsu_rdata_o     = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= RESET_RDATA;
      funct3_q <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.lsu_req_i) begin
            funct3_q <= bus.lsu_funct3_i;
            off_q    <= req_off;
            wdata_q  <= bus.lsu_wdata_i[15:0];
            waddr_q  <= bus.lsu_addr_i[ADDR_W-1:2];
            if (trap) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (!bus.lsu_we_i) begin
              state  <= LOAD_WAIT;
              busy_q <= 1'b1;
            end else if (req_word) begin
              done_q <= 1'b1;
            end else begin
              state  <= RMW;
              busy_q <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          rdata_q <= ld_ext;
          done_q  <= 1'b1;
          state   <= IDLE;
          busy_q  <= 1'b0;
        end
        RMW: begin
          done_q <= 1'b1;
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  a_no_ren_wren: assert property (@(posedge clk) disable iff (!rst_n) !(ren_c && wren_c));
  a_done_idle:   assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);
  a_err_done:    assert property (@(posedge clk) disable iff (!rst_n) err_q |-> done_q);

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed plan scenarios plus random traffic against a byte-array model.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_W(32)) bus();
  lsu_mem_port #(.ADDR_W(32), .RESET_RDATA(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Data memory: registered read, full-word write, 64 words.
  logic [31:0] mem_w [64];
  logic [31:0] rd_q = 32'h0;
  assign bus.mem_rdata_i = rd_q;
  always @(posedge clk) begin
    if (bus.ctrl_mem_wren_o) mem_w[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    if (bus.ctrl_mem_ren_o) rd_q <= mem_w[bus.mem_addr_o[7:2]];
  end

  // Reference: plain byte-addressed memory and the extension rules.
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata = 32'h0;

  function automatic int op_bytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    int n;
    int base;
    logic [31:0] v;
    n = op_bytes(f3);
    base = (a / n) * n;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, ref_mem[base + i]} << (8 * i));
    if (n == 1 && !f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    if (n == 2 && !f3[2] && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
    int n;
    int base;
    logic [31:0] sh;
    n = op_bytes(f3);
    base = (a / n) * n;
    for (int i = 0; i < n; i++) begin
      sh = wd >> (8 * i);
      ref_mem[base + i] = sh[7:0];
    end
  endtask

  task automatic poke(input int a, input logic [7:0] b);
    logic [31:0] w;
    ref_mem[a] = b;
    w = mem_w[a / 4];
    w[(a % 4) * 8 +: 8] = b;
    mem_w[a / 4] = w;
  endtask

  // Drives one request from an idle cycle and records what the DUT did, cycle 0 = accept cycle.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output int ren_cyc, output int wren_cyc, output int done_cyc, output int nwren,
                        output logic err_seen, output logic overlap, output logic [31:0] ren_addr,
                        output logic [31:0] wren_addr, output logic [31:0] wren_dat);
    ren_cyc = -1; wren_cyc = -1; done_cyc = -1; nwren = 0;
    err_seen = 1'b0; overlap = 1'b0; ren_addr = '0; wren_addr = '0; wren_dat = '0;
    bus.lsu_req_i = 1'b1;
    bus.lsu_we_i = we;
    bus.lsu_funct3_i = f3;
    bus.lsu_addr_i = addr;
    bus.lsu_wdata_i = wd;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.ctrl_mem_ren_o && bus.ctrl_mem_wren_o) overlap = 1'b1;
      if (bus.ctrl_mem_ren_o && ren_cyc < 0) begin
        ren_cyc = c;
        ren_addr = bus.mem_addr_o;
      end
      if (bus.ctrl_mem_wren_o) begin
        nwren++;
        wren_cyc = c;
        wren_addr = bus.mem_addr_o;
        wren_dat = bus.mem_wdata_o;
      end
      if (bus.lsu_err_o) err_seen = 1'b1;
      if (bus.lsu_done_o && done_cyc < 0) done_cyc = c;
      @(posedge clk);
      #1;
      bus.lsu_req_i = 1'b0;
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_funct3_i = '0;
    bus.lsu_addr_i = '0; bus.lsu_wdata_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.lsu_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.lsu_busy_o); end
    checks++; if (bus.lsu_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.lsu_done_o); end
    checks++; if (bus.lsu_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.lsu_err_o); end
    checks++; if (bus.lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", bus.lsu_rdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ctrl_mem_ren_o, bus.ctrl_mem_wren_o, bus.mem_addr_o, bus.mem_wdata_o} !== 66'h0) begin
      errors++;
      $display("FAIL idle_mem_outputs: got ren=%b wren=%b addr=%h wdata=%h want all 0",
               bus.ctrl_mem_ren_o, bus.ctrl_mem_wren_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h10, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFF_FFF3, 32'h0000_0082, 32'hFFFF_8081, 32'h0000_8081, 32'h8081_82F3};
    int rc, wc, dc, nw;
    logic es, ov;
    logic [31:0] ra, wa, wdd;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, f3s[i], adrs[i], 32'h0, rc, wc, dc, nw, es, ov, ra, wa, wdd);
      exp_rdata = exps[i];
      checks++; if (bus.lsu_rdata_o !== exps[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, bus.lsu_rdata_o, exps[i]); end
      checks++; if (rc !== 0) begin errors++; $display("FAIL load%0d_ren_cycle: got %0d want 0", i, rc); end
      checks++; if (dc !== 2) begin errors++; $display("FAIL load%0d_done_cycle: got %0d want 2", i, dc); end
      checks++; if (ra !== 32'h10) begin errors++; $display("FAIL load%0d_mem_addr: got %h want 00000010", i, ra); end
      checks++; if (nw !== 0) begin errors++; $display("FAIL load%0d_wren_count: got %0d want 0", i, nw); end
    end
  endtask

  task automatic test_sb_rmw();
    int rc, wc, dc, nw;
    logic es, ov;
    logic [31:0] ra, wa, wdd;
    run_op(1'b1, 3'b000, 32'h11, 32'h1234_56AA, rc, wc, dc, nw, es, ov, ra, wa, wdd);
    ref_store(3'b000, 32'h11, 32'h1234_56AA);
    checks++; if (rc !== 0) begin errors++; $display("FAIL sb_ren_cycle: got %0d want 0", rc); end
    checks++; if (wc !== 1 || nw !== 1) begin errors++; $display("FAIL sb_wren: got cycle %0d count %0d want cycle 1 count 1", wc, nw); end
    checks++; if (wdd !== 32'h8081_AAF3) begin errors++; $display("FAIL sb_merge: got %h want 8081aaf3", wdd); end
    checks++; if (wa !== 32'h10) begin errors++; $display("FAIL sb_waddr: got %h want 00000010", wa); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL sb_done_cycle: got %0d want 2", dc); end
    checks++; if (bus.lsu_rdata_o !== exp_rdata) begin errors++; $display("FAIL sb_rdata_held: got %h want %h", bus.lsu_rdata_o, exp_rdata); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, wc, dc, nw, es, ov, ra, wa, wdd);
    exp_rdata = 32'h8081_AAF3;
    checks++; if (bus.lsu_rdata_o !== exp_rdata) begin errors++; $display("FAIL sb_readback: got %h want %h", bus.lsu_rdata_o, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    // SW then LW presented in the SW done cycle.
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_funct3_i = 3'b010;
    bus.lsu_addr_i = 32'h14; bus.lsu_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.ctrl_mem_wren_o !== 1'b1 || bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_wren_c0: got wren=%b wdata=%h want 1 deadbeef", bus.ctrl_mem_wren_o, bus.mem_wdata_o); end
    @(posedge clk); #1;
    ref_store(3'b010, 32'h14, 32'hDEAD_BEEF);
    bus.lsu_we_i = 1'b0; bus.lsu_wdata_i = 32'h0;
    @(negedge clk);
    checks++; if (bus.lsu_done_o !== 1'b1) begin errors++; $display("FAIL sw_done_c1: got %b want 1", bus.lsu_done_o); end
    checks++; if (bus.ctrl_mem_ren_o !== 1'b1 || bus.mem_addr_o !== 32'h14) begin
      errors++; $display("FAIL b2b_accept: got ren=%b addr=%h want 1 00000014", bus.ctrl_mem_ren_o, bus.mem_addr_o); end
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0;
    @(negedge clk); @(negedge clk);
    exp_rdata = 32'hDEAD_BEEF;
    checks++; if (bus.lsu_done_o !== 1'b1 || bus.lsu_rdata_o !== exp_rdata) begin
      errors++; $display("FAIL b2b_lw: got done=%b rdata=%h want 1 %h", bus.lsu_done_o, bus.lsu_rdata_o, exp_rdata); end
    @(posedge clk); #1;
    // SB, then LW held through the busy cycle.
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_funct3_i = 3'b000;
    bus.lsu_addr_i = 32'h15; bus.lsu_wdata_i = 32'h0000_0077;
    @(posedge clk); #1;
    ref_store(3'b000, 32'h15, 32'h77);
    bus.lsu_we_i = 1'b0; bus.lsu_funct3_i = 3'b010; bus.lsu_addr_i = 32'h14;
    @(negedge clk);
    checks++; if (bus.lsu_busy_o !== 1'b1 || bus.ctrl_mem_ren_o !== 1'b0) begin
      errors++; $display("FAIL busy_ignore: got busy=%b ren=%b want 1 0", bus.lsu_busy_o, bus.ctrl_mem_ren_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.lsu_done_o !== 1'b1 || bus.ctrl_mem_ren_o !== 1'b1) begin
      errors++; $display("FAIL busy_held_accept: got done=%b ren=%b want 1 1", bus.lsu_done_o, bus.ctrl_mem_ren_o); end
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0;
    @(negedge clk); @(negedge clk);
    exp_rdata = ref_load(3'b010, 32'h14);
    checks++; if (bus.lsu_rdata_o !== 32'hDEAD_77EF) begin errors++; $display("FAIL held_lw_rdata: got %h want dead77ef", bus.lsu_rdata_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_rmw();
    int bad_wren = 0;
    int bad_done = 0;
    int rc, wc, dc, nw;
    logic es, ov;
    logic [31:0] ra, wa, wdd;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_funct3_i = 3'b001;
    bus.lsu_addr_i = 32'h10; bus.lsu_wdata_i = 32'h0000_5555;
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.ctrl_mem_wren_o !== 1'b0) begin errors++; $display("FAIL rst_rmw_wren: got %b want 0", bus.ctrl_mem_wren_o); end
    checks++; if (bus.lsu_busy_o !== 1'b0 || bus.lsu_done_o !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_busy_done: got busy=%b done=%b want 0 0", bus.lsu_busy_o, bus.lsu_done_o); end
    checks++; if (bus.lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rmw_rdata: got %h want 00000000", bus.lsu_rdata_o); end
    exp_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ctrl_mem_wren_o) bad_wren++;
      if (bus.lsu_done_o) bad_done++;
    end
    checks++; if (bad_wren !== 0 || bad_done !== 0) begin
      errors++; $display("FAIL rst_rmw_after: got wren=%0d done=%0d pulses want 0 0", bad_wren, bad_done); end
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, wc, dc, nw, es, ov, ra, wa, wdd);
    exp_rdata = ref_load(3'b010, 32'h10);
    checks++; if (bus.lsu_rdata_o !== exp_rdata) begin errors++; $display("FAIL rst_rmw_mem_kept: got %h want %h", bus.lsu_rdata_o, exp_rdata); end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b001};
    logic [31:0] ads [3] = '{32'h13, 32'h11, 32'h13};
    logic        wes [3] = '{1'b0, 1'b0, 1'b1};
    int rc, wc, dc, nw;
    logic es, ov;
    logic [31:0] ra, wa, wdd;
    for (int i = 0; i < 3; i++) begin
      run_op(wes[i], f3s[i], ads[i], 32'hCAFE_F00D, rc, wc, dc, nw, es, ov, ra, wa, wdd);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (es !== 1'b1 || dc !== 1) begin errors++; $display("FAIL mis%0d_trap: got err=%b done_cycle=%0d want 1 1", i, es, dc); end
      checks++; if (rc !== -1 || nw !== 0) begin errors++; $display("FAIL mis%0d_no_access: got ren_cycle=%0d wren=%0d want -1 0", i, rc, nw); end
`else
      if (wes[i]) ref_store(f3s[i], int'(ads[i]), 32'hCAFE_F00D);
      else exp_rdata = ref_load(f3s[i], int'(ads[i]));
      checks++; if (es !== 1'b0) begin errors++; $display("FAIL mis%0d_err: got %b want 0", i, es); end
      checks++; if (rc !== 0 || ra !== {ads[i][31:2], 2'b00}) begin
        errors++; $display("FAIL mis%0d_aligned_read: got cycle %0d addr %h want 0 %h", i, rc, ra, {ads[i][31:2], 2'b00}); end
`endif
      checks++; if (bus.lsu_rdata_o !== exp_rdata) begin errors++; $display("FAIL mis%0d_rdata: got %h want %h", i, bus.lsu_rdata_o, exp_rdata); end
    end
  endtask

  task automatic test_random();
    int rc, wc, dc, nw, exp_dc, exp_nw;
    logic es, ov, we, trap;
    logic [2:0] f3;
    logic [31:0] a, wd, ra, wa, wdd;
    for (int k = 0; k < 200; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (int'(a) % op_bytes(f3)) != 0;
`else
      trap = 1'b0;
`endif
      exp_dc = trap ? 1 : (!we ? 2 : (f3[1] ? 1 : 2));
      exp_nw = (trap || !we) ? 0 : 1;
      if (!trap && !we) exp_rdata = ref_load(f3, int'(a));
      run_op(we, f3, a, wd, rc, wc, dc, nw, es, ov, ra, wa, wdd);
      if (!trap && we) ref_store(f3, int'(a), wd);
      checks++; if (dc !== exp_dc || nw !== exp_nw || es !== trap || ov !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_ctrl: got done_cycle=%0d wren=%0d err=%b overlap=%b want %0d %0d %b 0",
                           k, dc, nw, es, ov, exp_dc, exp_nw, trap); end
      checks++; if (bus.lsu_rdata_o !== exp_rdata) begin
        errors++; $display("FAIL rnd%0d_rdata: we=%b f3=%b addr=%h got %h want %h", k, we, f3, a, bus.lsu_rdata_o, exp_rdata); end
    end
    for (int w = 0; w < 64; w++) begin
      run_op(1'b0, 3'b010, 32'(w * 4), 32'h0, rc, wc, dc, nw, es, ov, ra, wa, wdd);
      exp_rdata = ref_load(3'b010, w * 4);
      checks++; if (bus.lsu_rdata_o !== exp_rdata) begin
        errors++; $display("FAIL sweep_word%0d: got %h want %h", w, bus.lsu_rdata_o, exp_rdata); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_w[i] = 32'h0;
    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));
    poke(32'h10, 8'hF3); poke(32'h11, 8'h82); poke(32'h12, 8'h81); poke(32'h13, 8'h80);
    test_reset();
    test_loads();
    test_sb_rmw();
    test_back_to_back();
    test_reset_mid_rmw();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
